// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
//
// Sends one byte to the keyboard over the open-drain clock/data pair.
// The sequence is: inhibit the clock, request-to-send, LSB-first data,
// odd parity, stop bit, then the device acknowledge.
// The two outputs are active-high pull-low enables for the pads.
// While tx_busy is high, the neighbouring receiver must ignore the wires.
//
// Optional feature macro: PS2_TX_TIMEOUT_EN
//   Defined: a watchdog runs from clock release until the ack completes.
//            When it expires, the block reports tx_err.
//   Undefined: the block waits indefinitely for the device.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | lines released, ready for a new byte
// INHIBIT    | ps2_clk held low for INHIBIT_CYCLES cycles
// REQ        | clock and data both low for one cycle (start bit)
// SHIFT      | clock released; data updated on each device clock fall
// WAIT_IDLE  | ack seen; waiting for both lines to return high
// FINISH     | one-cycle tx_done/tx_err pulse, then back to IDLE

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;

  // The inhibit timer counts down from INHIBIT_CYCLES-1.
  // Leaving INHIBIT on the zero count gives exactly INHIBIT_CYCLES cycles.
  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);

  logic [2:0]       state;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       data_q;
  logic             par_q;
  logic             data_oe_q;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic clk_fall;
  logic accept;
  logic timeout_hit;

  // Two-flop synchronizers on both lines, plus a history flop for clock-fall detection.
  // The flops reset to 1 (the idle bus level), so reset never produces a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;
  assign accept   = tx_valid & (state == ST_IDLE);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // Watchdog down-counter: loaded while in REQ, counts during SHIFT and WAIT_IDLE.
  // It expires TIMEOUT_CYCLES cycles after the clock is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ST_REQ) begin
      to_cnt <= TO_LOAD;
    end else if (((state == ST_SHIFT) || (state == ST_WAIT_IDLE)) && (to_cnt != '0)) begin
      to_cnt <= to_cnt - TO_W'(1);
    end
  end

  assign timeout_hit = ((state == ST_SHIFT) || (state == ST_WAIT_IDLE)) && (to_cnt == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  // Transfer sequencer.
  // data_oe is registered, so it moves exactly one cycle after the fall is seen.
  // A device event on the same cycle takes precedence over the watchdog,
  // so done and err can never both be raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      inh_cnt   <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      data_oe_q <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= tx_data;
            par_q   <= ~^tx_data;
            inh_cnt <= INH_LOAD;
            state   <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (inh_cnt == '0) begin
            data_oe_q <= 1'b1;
            state     <= ST_REQ;
          end else begin
            inh_cnt <= inh_cnt - INH_W'(1);
          end
        end

        ST_REQ: begin
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (clk_fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              data_oe_q <= ~data_q[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              data_oe_q <= ~par_q;
            end else if (bit_cnt == 4'd9) begin
              data_oe_q <= 1'b0;
            end else if (!data_sync) begin
              state <= ST_WAIT_IDLE;
            end else begin
              tx_err <= 1'b1;
              state  <= ST_FINISH;
            end
          end else if (timeout_hit) begin
            tx_err    <= 1'b1;
            data_oe_q <= 1'b0;
            state     <= ST_FINISH;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            tx_done <= 1'b1;
            state   <= ST_FINISH;
          end else if (timeout_hit) begin
            tx_err    <= 1'b1;
            data_oe_q <= 1'b0;
            state     <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          data_oe_q <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          data_oe_q <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_REQ);
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state == ST_IDLE);
  assign tx_busy     = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx.
// A bus-level device model drives the PS/2 wires.
// A cycle-accurate expectation model, built from line-level timing rules,
// is compared against every DUT output on each falling clock edge.
`timescale 1ns/1ps

module tb_ps2_host_tx;

  localparam int INH = 12;
  localparam int TO  = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_line, ps2_data_line;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .ps2_clk_i(ps2_clk_line), .ps2_data_i(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Expectation model.
  // The model holds the acceptance cycle, a list of timed data_oe changes,
  // and the cycles in which tx_done and tx_err are due.
  typedef struct { int at; logic val; } ev_t;
  ev_t        sched[$];
  bit         active = 0;
  int         m_n = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_doe = 1'b0;
  int         t_done = -1;
  int         t_err = -1;
  bit         jitter_en = 0;
  logic [9:0] rx_bits;

  function void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  function void sched_at(input int at, input logic v);
    ev_t e;
    e.at = at;
    e.val = v;
    sched.push_back(e);
  endfunction

  function int t_end();
    return (t_done >= 0) ? t_done : t_err;
  endfunction

  function bit model_busy();
    return active && (cyc >= m_n) && ((t_end() < 0) || (cyc <= t_end()));
  endfunction

  function logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // Per-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0;
      sched.delete();
      m_doe = 1'b0;
      t_done = -1;
      t_err = -1;
    end else begin
      for (int i = 0; i < sched.size(); ) begin
        if (sched[i].at <= cyc) begin
          m_doe = sched[i].val;
          sched.delete(i);
        end else begin
          i++;
        end
      end
      chk("tx_ready", tx_ready, !model_busy());
      chk("tx_busy", tx_busy, model_busy());
      chk("ps2_clk_oe", ps2_clk_oe, active && (cyc >= m_n) && (cyc <= m_n + INH));
      chk("ps2_data_oe", ps2_data_oe, m_doe);
      chk("tx_done", tx_done, active && (cyc == t_done));
      chk("tx_err", tx_err, active && (cyc == t_err));
      if (!model_busy() && tx_valid) begin
        active = 1;
        m_n = cyc + 1;
        m_byte = tx_data;
        t_done = -1;
        t_err = -1;
        sched_at(m_n + INH, 1'b1);
      end
    end
  end

  // Scramble tx_data while a transfer is in flight. Only the byte captured
  // at acceptance may appear on the wire.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (jitter_en && model_busy()) tx_data = 8'($urandom);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Keyboard model: waits for the request to send, then clocks out 11 falls.
  // It samples host data just before each rising edge and optionally acks.
  task automatic run_device(input bit ack, input int abort_k, input int lo, input int hi);
    bit ok;
    ok = 0;
    for (int i = 0; i < INH + 60; i++) begin
      step();
      if (ps2_clk_line == 1'b0) begin ok = 1; break; end
    end
    chk("req_clk_low", ok, 1'b1);
    if (!ok) return;
    ok = 0;
    for (int i = 0; i < INH + 60; i++) begin
      step();
      if (ps2_clk_line == 1'b1) begin ok = 1; break; end
    end
    chk("req_clk_release", ok, 1'b1);
    if (!ok) return;
    chk("start_bit", ps2_data_line, 1'b0);
    repeat (4) step();
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (k <= 8)       sched_at(cyc + 3, ~m_byte[k-1]);
      else if (k == 9)  sched_at(cyc + 3, ~odd_par(m_byte));
      else if (k == 10) sched_at(cyc + 3, 1'b0);
      else if (!ack)    t_err = cyc + 3;
      repeat (lo) step();
      if (k == abort_k) return;
      if (k <= 10) rx_bits[k-1] = ps2_data_line;
      dev_clk_low = 1'b0;
      if (k == 10 && ack) dev_data_low = 1'b1;
      if (k == 11) break;
      repeat (hi) step();
    end
    if (ack) begin
      repeat (4) step();
      dev_data_low = 1'b0;
      t_done = cyc + 3;
    end
  endtask

  task automatic wait_end();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (t_end() >= 0 && cyc >= t_end()) tx_valid = 1'b0;
      if (t_end() >= 0 && cyc > t_end() + 1) return;
    end
    chk("transfer_end_timeout", 1'b0, 1'b1);
  endtask

  task automatic send(input logic [7:0] b, input bit ack, input bit hold, input int abort_k,
                      output logic [9:0] got);
    int lo, hi;
    lo = $urandom_range(6, 14);
    hi = $urandom_range(6, 14);
    rx_bits = '0;
    step();
    tx_data = b;
    tx_valid = 1'b1;
    if (!hold) begin
      step();
      tx_valid = 1'b0;
    end else begin
      jitter_en = 1;
    end
    run_device(ack, abort_k, lo, hi);
    if (abort_k == 0) wait_end();
    tx_valid = 1'b0;
    jitter_en = 0;
    got = rx_bits;
  endtask

  logic [9:0] got;
  logic [7:0] rb;
  bit         rack;

  initial begin
    repeat (3) step();
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_err", tx_err, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();

    send(8'hED, 1, 0, 0, got);
    chk("frame_ED", got, 10'h3ED);
    send(8'hF4, 1, 0, 0, got);
    chk("frame_F4", got, 10'h2F4);

    rb = 8'($urandom);
    send(rb, 0, 0, 0, got);
    chk("frame_noack", got, {1'b1, odd_par(rb), rb});

    send(8'hA7, 1, 1, 0, got);
    chk("frame_hold_A7", got, 10'h2A7);
    repeat (5) step();

    // Abort after fall 4. Bit 3 of 0xA5 is 0, so data is being pulled low.
    send(8'hA5, 1, 0, 4, got);
    chk("pre_reset_data_oe", ps2_data_oe, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_clk_oe", ps2_clk_oe, 1'b0);
    chk("abort_data_oe", ps2_data_oe, 1'b0);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) step();
    chk("abort_done", tx_done, 1'b0);
    chk("abort_err", tx_err, 1'b0);
    chk("abort_ready", tx_ready, 1'b1);
    rst_n = 1'b1;
    repeat (3) step();
    send(8'h00, 1, 0, 0, got);
    chk("frame_00", got, 10'h300);

    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      send(rb, rack, 0, 0, got);
      chk("frame_random", got, {1'b1, odd_par(rb), rb});
      repeat ($urandom_range(0, 5)) step();
    end

`ifdef PS2_TX_TIMEOUT_EN
    // Silent device: the watchdog fires TO cycles after the clock is released.
    step();
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    t_err = m_n + INH + 1 + TO;
    sched_at(t_err, 1'b0);
    wait_end();
    chk("timeout_clk_oe", ps2_clk_oe, 1'b0);
    chk("timeout_data_oe", ps2_data_oe, 1'b0);
`endif

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
